onehot_codec: RTL
=================

Name: onehot_codec

Overview:
- Registered, bidirectional binary/one-hot converter with valid/ready handshakes on both sides and a 2-entry output buffer, so it sustains one conversion per cycle under backpressure.
- Per-transaction mode selects binary->one-hot (encode) or one-hot->binary (decode).
- Flags illegal codes and keeps a saturating error count.
- Sits between decode/select logic and downstream consumers that need a registered, flow-controlled code.

Parameters:
- BIN_W, 4, width of the binary code.
- ONE_HOT_W, 16, width of the one-hot code; legal range 2..2**BIN_W.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_n_i, input, 1, asynchronous active-low reset.
- in_valid_i, input, 1, input transaction valid.
- in_ready_o, output, 1, block can accept an input this cycle.
- mode_i, input, 1, 0 = encode (bin_i -> one-hot), 1 = decode (one_hot_i -> binary).
- bin_i, input, BIN_W, binary operand; used when mode_i=0.
- one_hot_i, input, ONE_HOT_W, one-hot operand; used when mode_i=1.
- out_valid_o, output, 1, output transaction valid.
- out_ready_i, input, 1, downstream accepts the output.
- out_mode_o, output, 1, mode of the presented result.
- one_hot_o, output, ONE_HOT_W, encode result; 0 in decode results.
- bin_o, output, BIN_W, decode result; 0 in encode results.
- err_o, output, 1, presented result came from an illegal operand.
- err_cnt_o, output, ERR_CNT_W, saturating count of accepted illegal operands.
- err_clr_i, input, 1, synchronous clear of err_cnt_o.

Behaviour:
- Reset (rst_n_i low, asynchronous, any time, including mid-transfer):
  - buffer emptied; out_valid_o=0, out_mode_o=0, one_hot_o=0, bin_o=0, err_o=0, err_cnt_o=0.
  - in_ready_o=1 while out of reset with empty buffer.
  - Any in-flight data is discarded.
- Handshake:
  - Input accepted when in_valid_i & in_ready_o.
  - Output consumed when out_valid_o & out_ready_i.
  - in_ready_o = (occupancy < 2), decoded from registered occupancy, with no combinational path from out_ready_i.
  - out_valid_o = (occupancy > 0).
  - out_valid_o and the presented payload stay stable until consumed.
- Latency:
  - Result accepted at edge N is presented from cycle N+1, assuming the buffer was empty or its head is consumed at edge N.
  - Results leave in strict acceptance order.
- Buffer:
  - 2-entry FIFO; head entry drives the outputs.
  - Simultaneous accept and consume: occupancy unchanged; new entry queued behind the remaining one.
  - When full, in_ready_o=0; when empty, outputs hold their last values but out_valid_o=0.
- Encode (mode 0):
  - bin_i < ONE_HOT_W: one_hot = 1 << bin_i, err=0.
  - bin_i >= ONE_HOT_W: one_hot = 0, err=1.
  - bin_o = 0 in both cases.
- Decode (mode 1):
  - Exactly one bit set: bin = index of that bit, err=0.
  - Zero bits set: bin=0, err=1.
  - More than one bit set: bin = index of the lowest set bit, err=1.
  - one_hot_o = 0 in all cases.
- Error counter:
  - Increments by 1 on each accepted transaction with err=1 (at acceptance, not output).
  - Saturates at all-ones.
  - err_clr_i wins over a same-cycle increment; result 0.
- Conversion is fully combinational ahead of the buffer write; no other pipeline stages.

Test Plan:
- Reset, then encode bin_i=9 with out_ready_i=1 -> next cycle out_valid_o=1, one_hot_o=0x0200, bin_o=0, err_o=0; err_cnt_o=0.
- Decode one_hot_i=0x0020 -> bin_o=5, err_o=0. Decode 0x0000 -> bin_o=0, err_o=1. Decode 0x0028 -> bin_o=3, err_o=1; err_cnt_o=2.
- BIN_W=4, ONE_HOT_W=10: encode bin_i=12 -> one_hot_o=0, err_o=1; bin_i=9 -> one_hot_o=0x200, err_o=0.
- Hold out_ready_i=0, stream encodes 1,2,3 -> first two accepted, in_ready_o=0 on third. Release -> outputs 0x2, 0x4, then 0x8, in order, payloads stable while stalled.
- Back-to-back 8 inputs, out_ready_i=1 -> one result per cycle, in_ready_o never drops.
- ERR_CNT_W=2: five illegal operands -> err_cnt_o saturates at 3. err_clr_i with a simultaneous illegal input -> err_cnt_o=0.
- Assert rst_n_i mid-stream with a full buffer -> out_valid_o=0 and err_cnt_o=0 immediately (asynchronous); no stale output after release.

Source files
------------

// File: rtl/onehot_codec.sv
// Registered binary<->one-hot converter with valid/ready handshakes and a
// 2-entry output buffer; flags illegal operands and counts them (saturating).
module onehot_codec #(
  parameter int unsigned BIN_W     = 4,
  parameter int unsigned ONE_HOT_W = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 mode_i,
  input  logic [BIN_W-1:0]     bin_i,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_mode_o,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  typedef struct packed {
    logic                 mode;
    logic [ONE_HOT_W-1:0] oh;
    logic [BIN_W-1:0]     bin;
    logic                 err;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  entry_t               r_head;
  entry_t               r_slot;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  entry_t               w_cv;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_load_head;
  logic                 w_load_slot;
  logic                 w_head_from_slot;

  assign w_push = in_valid_i & r_in_ready;
  assign w_pop  = r_out_valid & out_ready_i;

  // Conversion of the incoming operand, ahead of the buffer write.
  always_comb begin
    w_cv      = '0;
    w_cv.mode = mode_i;
    if (!mode_i) begin
      if (32'(bin_i) < ONE_HOT_W) begin
        w_cv.oh = ONE_HOT_W'(1) << bin_i;
      end else begin
        w_cv.err = 1'b1;
      end
    end else begin
      // Descending scan leaves the lowest set bit's index.
      for (int i = int'(ONE_HOT_W) - 1; i >= 0; i--) begin
        if (one_hot_i[i]) begin
          w_cv.bin = BIN_W'(i);
        end
      end
      w_cv.err = (one_hot_i == '0) ||
                 ((one_hot_i & (one_hot_i - ONE_HOT_W'(1))) != '0);
    end
  end

  // Buffer occupancy: next state and entry-move controls.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_load_slot      = 1'b0;
    w_head_from_slot = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_load_head = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_load_head = 1'b1;
        end else if (w_push) begin
          w_load_slot = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_head_from_slot = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Handshake flags are registered from the next occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head <= '0;
      r_slot <= '0;
    end else begin
      if (w_load_head) begin
        r_head <= w_cv;
      end else if (w_head_from_slot) begin
        r_head <= r_slot;
      end
      if (w_load_slot) begin
        r_slot <= w_cv;
      end
    end
  end

  // Counted at acceptance; clear has priority over increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if (w_push && w_cv.err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_mode_o  = r_head.mode;
  assign one_hot_o   = r_head.oh;
  assign bin_o       = r_head.bin;
  assign err_o       = r_head.err;
  assign err_cnt_o   = r_err_cnt;

endmodule
